// File: rtl/sram_write_buffer.sv
// In-order store buffer between the core data port and the SRAM-to-AXI bridge; reads wait for the buffer to drain.
// Latency: write ack one cycle after accept, mem_req from the next cycle; read ack combinational with mem_data_ok.
// Backpressure: cpu_addr_ok drops when full or a read is outstanding; WB_UNCACHED_STRICT_EN makes uncached writes synchronous.

module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  store_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) store_q[wr_ptr] <= push_dat;
  end

  assign head_dat = store_q[rd_ptr];
endmodule

module sram_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_uncached,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_uncached,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic        uncached;
  } wb_entry_t;

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} state_t;

  state_t        state;
  wb_entry_t     push_ent;
  wb_entry_t     head_ent;
  wb_entry_t     rd_hold;
  wb_entry_t     mem_ent;
  logic [CW-1:0] count;
  logic          in_read;
  logic          wr_side;
  logic          wr_accept;
  logic          rd_accept;
  logic          pop;
  logic          wr_ack_q;
  logic          unc_ok;
  logic          unc_sync;
  logic          unc_pend;
  logic          unc_done;

  assign push_ent = '{addr: cpu_addr, size: cpu_size, wdata: cpu_wdata, uncached: cpu_uncached};
  assign in_read  = (state == RD_ADDR) || (state == RD_DATA);
  assign wr_side  = (state == WR_ADDR) || (state == WR_DATA);

`ifdef WB_UNCACHED_STRICT_EN
  // A synchronous uncached write is the only entry in flight, so its pop is its completion.
  assign unc_ok   = !cpu_uncached || ((state == IDLE) && (count == '0));
  assign unc_sync = cpu_uncached;
  assign unc_done = unc_pend && (state == WR_DATA) && mem_data_ok;

  always_ff @(posedge clk) begin
    if (rst)                          unc_pend <= 1'b0;
    else if (wr_accept && unc_sync)   unc_pend <= 1'b1;
    else if (unc_done)                unc_pend <= 1'b0;
  end
`else
  assign unc_ok   = 1'b1;
  assign unc_sync = 1'b0;
  assign unc_pend = 1'b0;
  assign unc_done = 1'b0;
`endif

  // Occupancy is the registered count, so a same-cycle pop never makes room for a push.
  assign wr_accept = !rst && cpu_req && cpu_wr && (count < CW'(DEPTH)) && !in_read && !unc_pend && unc_ok;
  assign rd_accept = !rst && cpu_req && !cpu_wr && (state == IDLE) && (count == '0) && !unc_pend;
  assign pop       = (state == WR_DATA) && mem_data_ok;

  wb_fifo #(.W($bits(wb_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wr_accept),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ack_q <= 1'b0;
      rd_hold  <= '0;
    end else begin
      wr_ack_q <= wr_accept && !unc_sync;
      if (rd_accept) rd_hold <= push_ent;
      case (state)
        IDLE: begin
          if ((count != '0) || wr_accept) state <= WR_ADDR;
          else if (rd_accept)             state <= RD_ADDR;
        end
        WR_ADDR: if (mem_addr_ok) state <= WR_DATA;
        WR_DATA: begin
          // count >= 1 here, so the post-pop occupancy is nonzero iff count > 1 or a push lands.
          if (mem_data_ok) state <= ((count > CW'(1)) || wr_accept) ? WR_ADDR : IDLE;
        end
        RD_ADDR: if (mem_addr_ok) state <= RD_DATA;
        RD_DATA: if (mem_data_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_ent      = wr_side ? head_ent : (in_read ? rd_hold : '0);
  assign mem_req      = (state == WR_ADDR) || (state == RD_ADDR);
  assign mem_wr       = wr_side;
  assign mem_size     = mem_ent.size;
  assign mem_addr     = mem_ent.addr;
  assign mem_wdata    = mem_ent.wdata;
  assign mem_uncached = mem_ent.uncached;

  assign cpu_addr_ok  = wr_accept || rd_accept;
  assign cpu_rdata    = (state == RD_DATA) ? mem_rdata : '0;
  assign cpu_data_ok  = !rst && (wr_ack_q || ((state == RD_DATA) && mem_data_ok) || unc_done);
endmodule

// File: tb/tb_sram_write_buffer.sv
// Directed cycle-accurate bench for sram_write_buffer; expectations follow WB_UNCACHED_STRICT_EN when defined.
module tb_sram_write_buffer;
`ifdef WB_UNCACHED_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, cpu_uncached;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_addr_ok, cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_wr, mem_uncached;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  sram_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_uncached(cpu_uncached),
    .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_uncached(mem_uncached),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cpu(input logic req, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic unc);
    cpu_req      = req;
    cpu_wr       = wr;
    cpu_size     = 2'd2;
    cpu_addr     = a;
    cpu_wdata    = d;
    cpu_uncached = unc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_cpu(1'b1, 1'b1, 32'h55, 32'h66, 1'b1);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick; tick;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, cpu_data_ok, mem_req, mem_wr} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl: got %b want 0000", {cpu_addr_ok, cpu_data_ok, mem_req, mem_wr});
    end
    vecs++;
    if ({mem_addr, mem_wdata, mem_size, mem_uncached, cpu_rdata} !== '0) begin
      errs++; $display("FAIL reset_data: addr %h wdata %h size %h unc %b rdata %h want all 0",
                       mem_addr, mem_wdata, mem_size, mem_uncached, cpu_rdata);
    end
    tick;
    rst = 1'b0; cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    @(negedge clk);
    vecs++;
    if ({mem_req, cpu_data_ok} !== 2'b00) begin
      errs++; $display("FAIL post_reset_idle: got %b want 00", {mem_req, cpu_data_ok});
    end
    tick;
  endtask

  task automatic test_single_write;
    mem_addr_ok = 1'b1;
    drive_cpu(1'b1, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, cpu_data_ok, mem_req} !== 3'b100) begin
      errs++; $display("FAIL single_t0: got %b want 100", {cpu_addr_ok, cpu_data_ok, mem_req});
    end
    tick;
    cpu_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata, mem_size, mem_uncached} !==
        {3'b111, 32'h1000_0000, 32'hDEAD_BEEF, 2'd2, 1'b0}) begin
      errs++; $display("FAIL single_t1: ok %b req %b wr %b addr %h data %h size %0d unc %b",
                       cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata, mem_size, mem_uncached);
    end
    tick;
    mem_data_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b00) begin
      errs++; $display("FAIL single_t2: got %b want 00", {cpu_data_ok, mem_req});
    end
    tick;
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b00) begin
      errs++; $display("FAIL single_t3: got %b want 00", {cpu_data_ok, mem_req});
    end
    tick;
  endtask

  task automatic test_fill_stall;
    logic [31:0] exp_addr;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cpu(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
      @(negedge clk);
      vecs++;
      if ({cpu_addr_ok, cpu_data_ok, mem_req} !== {1'b1, (i != 0), (i != 0)}) begin
        errs++; $display("FAIL fill_accept%0d: got %b want %b", i,
                         {cpu_addr_ok, cpu_data_ok, mem_req}, {1'b1, (i != 0), (i != 0)});
      end
      tick;
    end
    drive_cpu(1'b1, 1'b1, 32'h110, 32'hA4, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vecs++;
      if ({cpu_addr_ok, cpu_data_ok, mem_addr} !== {1'b0, (j == 0), 32'h100}) begin
        errs++; $display("FAIL full_stall%0d: addr_ok %b data_ok %b mem_addr %h", j,
                         cpu_addr_ok, cpu_data_ok, mem_addr);
      end
      tick;
    end
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, mem_req} !== 2'b00) begin
      errs++; $display("FAIL full_pop_cycle: got %b want 00", {cpu_addr_ok, mem_req});
    end
    tick;
    mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, mem_req, mem_addr, mem_wdata} !== {2'b11, 32'h104, 32'hA1}) begin
      errs++; $display("FAIL full_after_pop: addr_ok %b req %b addr %h data %h",
                       cpu_addr_ok, mem_req, mem_addr, mem_wdata);
    end
    tick;
    cpu_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b10) begin
      errs++; $display("FAIL fifth_ack: got %b want 10", {cpu_data_ok, mem_req});
    end
    tick;
    for (int k = 2; k < 5; k++) begin
      exp_addr = 32'h100 + 32'(4 * k);
      mem_data_ok = 1'b0; mem_addr_ok = 1'b1;
      @(negedge clk);
      vecs++;
      if ({mem_req, mem_addr, mem_wdata} !== {1'b1, exp_addr, 32'hA0 + 32'(k)}) begin
        errs++; $display("FAIL drain_order%0d: req %b addr %h data %h want addr %h", k,
                         mem_req, mem_addr, mem_wdata, exp_addr);
      end
      tick;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
      tick;
    end
    mem_data_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if (mem_req !== 1'b0) begin
      errs++; $display("FAIL drain_done: mem_req %b want 0", mem_req);
    end
    tick;
  endtask

  task automatic test_raw;
    drive_cpu(1'b1, 1'b1, 32'h80, 32'h1234_5678, 1'b0);
    @(negedge clk);
    vecs++;
    if (cpu_addr_ok !== 1'b1) begin
      errs++; $display("FAIL raw_wr_accept: addr_ok %b want 1", cpu_addr_ok);
    end
    tick;
    drive_cpu(1'b1, 1'b0, 32'h80, 32'h0, 1'b0);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata} !==
        {4'b0111, 32'h80, 32'h1234_5678}) begin
      errs++; $display("FAIL raw_wr_issue: addr_ok %b data_ok %b req %b wr %b addr %h data %h",
                       cpu_addr_ok, cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata);
    end
    tick;
    mem_addr_ok = 1'b0;
    tick;
    mem_data_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if (cpu_addr_ok !== 1'b0) begin
      errs++; $display("FAIL raw_rd_held: addr_ok %b want 0", cpu_addr_ok);
    end
    tick;
    mem_data_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, mem_req} !== 2'b10) begin
      errs++; $display("FAIL raw_rd_accept: got %b want 10", {cpu_addr_ok, mem_req});
    end
    tick;
    cpu_req = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({mem_req, mem_wr, mem_addr, mem_size} !== {2'b10, 32'h80, 2'd2}) begin
      errs++; $display("FAIL raw_rd_issue: req %b wr %b addr %h size %0d", mem_req, mem_wr, mem_addr, mem_size);
    end
    tick;
    mem_addr_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b00) begin
      errs++; $display("FAIL raw_rd_wait: got %b want 00", {cpu_data_ok, mem_req});
    end
    tick;
    mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, cpu_rdata} !== {1'b1, 32'h1234_5678}) begin
      errs++; $display("FAIL raw_rd_data: data_ok %b rdata %h want 1 12345678", cpu_data_ok, cpu_rdata);
    end
    tick;
    mem_data_ok = 1'b0; mem_rdata = '0;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b00) begin
      errs++; $display("FAIL raw_done: got %b want 00", {cpu_data_ok, mem_req});
    end
    tick;
  endtask

  task automatic test_read_blocks_write;
    drive_cpu(1'b1, 1'b0, 32'h200, 32'h0, 1'b0);
    @(negedge clk);
    vecs++;
    if (cpu_addr_ok !== 1'b1) begin
      errs++; $display("FAIL rbw_rd_accept: addr_ok %b want 1", cpu_addr_ok);
    end
    tick;
    drive_cpu(1'b1, 1'b1, 32'h204, 32'h0BAD_F00D, 1'b0);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, mem_req, mem_wr} !== 3'b010) begin
      errs++; $display("FAIL rbw_rd_addr: got %b want 010", {cpu_addr_ok, mem_req, mem_wr});
    end
    tick;
    mem_addr_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if (cpu_addr_ok !== 1'b0) begin
      errs++; $display("FAIL rbw_rd_data_wait: addr_ok %b want 0", cpu_addr_ok);
    end
    tick;
    mem_data_ok = 1'b1; mem_rdata = 32'hCAFE_0000;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, cpu_data_ok, cpu_rdata} !== {2'b01, 32'hCAFE_0000}) begin
      errs++; $display("FAIL rbw_rd_done: addr_ok %b data_ok %b rdata %h", cpu_addr_ok, cpu_data_ok, cpu_rdata);
    end
    tick;
    mem_data_ok = 1'b0; mem_rdata = '0;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, cpu_data_ok} !== 2'b10) begin
      errs++; $display("FAIL rbw_wr_accept: got %b want 10", {cpu_addr_ok, cpu_data_ok});
    end
    tick;
    cpu_req = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata} !== {3'b111, 32'h204, 32'h0BAD_F00D}) begin
      errs++; $display("FAIL rbw_wr_issue: ok %b req %b wr %b addr %h data %h",
                       cpu_data_ok, mem_req, mem_wr, mem_addr, mem_wdata);
    end
    tick;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick;
    mem_data_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if (mem_req !== 1'b0) begin
      errs++; $display("FAIL rbw_done: mem_req %b want 0", mem_req);
    end
    tick;
  endtask

  task automatic test_uncached;
    drive_cpu(1'b1, 1'b1, 32'hBFAF_0000, 32'h5A5A_0001, 1'b1);
    @(negedge clk);
    vecs++;
    if (cpu_addr_ok !== 1'b1) begin
      errs++; $display("FAIL unc_accept: addr_ok %b want 1", cpu_addr_ok);
    end
    tick;
    cpu_req = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req, mem_uncached, mem_addr} !== {!STRICT, 2'b11, 32'hBFAF_0000}) begin
      errs++; $display("FAIL unc_t1: data_ok %b req %b unc %b addr %h want data_ok %b",
                       cpu_data_ok, mem_req, mem_uncached, mem_addr, !STRICT);
    end
    tick;
    mem_addr_ok = 1'b0;
    for (int j = 2; j < 5; j++) begin
      @(negedge clk);
      vecs++;
      if (cpu_data_ok !== 1'b0) begin
        errs++; $display("FAIL unc_wait%0d: data_ok %b want 0", j, cpu_data_ok);
      end
      tick;
    end
    mem_data_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if (cpu_data_ok !== STRICT) begin
      errs++; $display("FAIL unc_t5: data_ok %b want %b", cpu_data_ok, STRICT);
    end
    tick;
    mem_data_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b00) begin
      errs++; $display("FAIL unc_done: got %b want 00", {cpu_data_ok, mem_req});
    end
    tick;
  endtask

  task automatic test_reset_mid;
    drive_cpu(1'b1, 1'b1, 32'h300, 32'h1, 1'b0);
    @(negedge clk);
    vecs++;
    if (cpu_addr_ok !== 1'b1) begin
      errs++; $display("FAIL rmid_acc0: addr_ok %b want 1", cpu_addr_ok);
    end
    tick;
    drive_cpu(1'b1, 1'b1, 32'h304, 32'h2, 1'b0);
    mem_addr_ok = 1'b1;
    tick;
    drive_cpu(1'b1, 1'b1, 32'h308, 32'h3, 1'b0);
    mem_addr_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, mem_req} !== 2'b10) begin
      errs++; $display("FAIL rmid_acc2: got %b want 10", {cpu_addr_ok, mem_req});
    end
    tick;
    cpu_req = 1'b0;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req} !== 2'b10) begin
      errs++; $display("FAIL rmid_wr_data: got %b want 10", {cpu_data_ok, mem_req});
    end
    tick;
    rst = 1'b1;
    drive_cpu(1'b1, 1'b1, 32'h30C, 32'h4, 1'b0);
    @(negedge clk);
    vecs++;
    if ({cpu_addr_ok, cpu_data_ok} !== 2'b00) begin
      errs++; $display("FAIL rmid_in_reset: got %b want 00", {cpu_addr_ok, cpu_data_ok});
    end
    tick;
    rst = 1'b0; cpu_req = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      vecs++;
      if ({mem_req, cpu_data_ok} !== 2'b00) begin
        errs++; $display("FAIL rmid_flushed%0d: got %b want 00", j, {mem_req, cpu_data_ok});
      end
      tick;
    end
    drive_cpu(1'b1, 1'b1, 32'h400, 32'h77, 1'b0);
    tick;
    cpu_req = 1'b0; mem_addr_ok = 1'b1;
    @(negedge clk);
    vecs++;
    if ({cpu_data_ok, mem_req, mem_addr, mem_wdata} !== {2'b11, 32'h400, 32'h77}) begin
      errs++; $display("FAIL rmid_fresh: ok %b req %b addr %h data %h want 1 1 400 77",
                       cpu_data_ok, mem_req, mem_addr, mem_wdata);
    end
    tick;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    tick;
    mem_data_ok = 1'b0;
    @(negedge clk);
    vecs++;
    if ({mem_req, cpu_data_ok} !== 2'b00) begin
      errs++; $display("FAIL rmid_end: got %b want 00", {mem_req, cpu_data_ok});
    end
    tick;
  endtask

  initial begin
    rst = 1'b1;
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    test_reset;
    test_single_write;
    test_fill_stall;
    test_raw;
    test_read_blocks_write;
    test_uncached;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
